axi_lite_regfile: RTL and testbench

AXI-Lite slave register bank that terminates the slave side of the `axi_lite_if` channel set. It provides NUM_REGS word-wide registers to the surrounding logic. Registers 0..NUM_REGS-2 are software read/write; register NUM_REGS-1 is a read-only status word fed from hardware. It sits directly downstream of any AXI-Lite master or interconnect and drives control fields into the datapath.

---
 rtl/axi_lite_regfile.sv | 172 +++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile
//   AXI-Lite slave register bank. Registers 0..NUM_REGS-2 are software
//   read/write. Register NUM_REGS-1 is a read-only status word taken from
//   status_in.
//
//   Optional feature macro: AXIL_REGFILE_WSTRB_EN
//     defined   : w_strb is applied per byte. Unstrobed bytes keep their old value.
//     undefined : w_strb is ignored, and every write replaces the full word.
//
//   Ports
//     clk, rst                  rising-edge clock, async active-high reset
//     aw_* / w_* / b_*          write address / data / response channels
//     ar_* / r_*                read address / data channels
//     status_in                 value returned for register NUM_REGS-1
//     regs_out                  flat copy of the RW registers (slot NUM_REGS-1 = 0)
module axi_lite_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          aw_addr,
  input  logic                           aw_valid,
  output logic                           aw_ready,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [DATA_WIDTH/8-1:0]        w_strb,
  input  logic                           w_valid,
  output logic                           w_ready,
  output logic [1:0]                     b_resp,
  output logic                           b_valid,
  input  logic                           b_ready,
  input  logic [ADDR_WIDTH-1:0]          ar_addr,
  input  logic                           ar_valid,
  output logic                           ar_ready,
  output logic [DATA_WIDTH-1:0]          r_data,
  output logic [1:0]                     r_resp,
  output logic                           r_valid,
  input  logic                           r_ready,
  input  logic [DATA_WIDTH-1:0]          status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int BYTE_BITS = $clog2(STRB_W);
  localparam int IDX_BITS  = $clog2(NUM_REGS);
  localparam int UA        = ADDR_WIDTH - BYTE_BITS;  // word-address width
  localparam int RO_IDX    = NUM_REGS - 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Only the RW registers are stored. The status slot is a constant zero in regs_out.
  logic [NUM_REGS-2:0][DATA_WIDTH-1:0] regs;

  // ---------------- write path ----------------
  logic                  aw_held, w_held;
  logic [UA-1:0]         aw_word_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  aw_hs, w_hs, commit;
  logic [UA-1:0]         aw_word;
  logic [DATA_WIDTH-1:0] wr_data, wmask;
  logic [IDX_BITS-1:0]   wr_idx;
  logic                  wr_err;

  assign aw_ready = !aw_held && !b_valid;
  assign w_ready  = !w_held && !b_valid;
  assign aw_hs    = aw_valid && aw_ready;
  assign w_hs     = w_valid && w_ready;

  // A commit may combine a held beat with a beat that is handshaking in the same cycle.
  assign aw_word = aw_held ? aw_word_q : aw_addr[ADDR_WIDTH-1:BYTE_BITS];
  assign wr_data = w_held ? w_data_q : w_data;
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_idx  = aw_word[IDX_BITS-1:0];
  assign wr_err  = (|aw_word[UA-1:IDX_BITS]) || (wr_idx == IDX_BITS'(RO_IDX));

`ifdef AXIL_REGFILE_WSTRB_EN
  logic [STRB_W-1:0] w_strb_q, wr_strb;
  assign wr_strb = w_held ? w_strb_q : w_strb;
  always_comb begin
    wmask = '0;
    for (int b = 0; b < STRB_W; b++) wmask[b*8 +: 8] = {8{wr_strb[b]}};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst)       w_strb_q <= '0;
    else if (w_hs) w_strb_q <= w_strb;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_addr[BYTE_BITS-1:0], ar_addr[BYTE_BITS-1:0]};
`else
  assign wmask = '1;
  logic unused_inputs;
  assign unused_inputs = ^{aw_addr[BYTE_BITS-1:0], ar_addr[BYTE_BITS-1:0], w_strb};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_word_q <= '0;
      w_data_q  <= '0;
      b_valid   <= 1'b0;
      b_resp    <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_word_q <= aw_addr[ADDR_WIDTH-1:BYTE_BITS];
      if (w_hs)  w_data_q  <= w_data;
      // No commit can occur while b_valid is high, because both ready signals are low
      // and the holds are already clear.
      if (b_valid && b_ready) begin
        b_valid <= 1'b0;
      end else if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        b_valid <= 1'b1;
        b_resp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (commit && !wr_err) begin
      for (int i = 0; i < NUM_REGS-1; i++)
        if (wr_idx == IDX_BITS'(i))
          regs[i] <= (regs[i] & ~wmask) | (wr_data & wmask);
    end
  end

  assign regs_out = {{DATA_WIDTH{1'b0}}, regs};

  // ---------------- read path ----------------
  logic [UA-1:0]         ar_word;
  logic [IDX_BITS-1:0]   rd_idx;
  logic                  rd_oor, ar_hs;
  logic [DATA_WIDTH-1:0] rd_val;

  assign ar_ready = !r_valid;
  assign ar_hs    = ar_valid && ar_ready;
  assign ar_word  = ar_addr[ADDR_WIDTH-1:BYTE_BITS];
  assign rd_idx   = ar_word[IDX_BITS-1:0];
  assign rd_oor   = |ar_word[UA-1:IDX_BITS];

  always_comb begin
    rd_val = '0;
    if (!rd_oor) begin
      if (rd_idx == IDX_BITS'(RO_IDX)) rd_val = status_in;
      else
        for (int i = 0; i < NUM_REGS-1; i++)
          if (rd_idx == IDX_BITS'(i)) rd_val = regs[i];
    end
  end

  // The register mux samples the pre-edge regs. A read on the same edge as a
  // write commit therefore returns the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
    end else if (ar_hs) begin
      r_valid <= 1'b1;
      r_data  <= rd_val;
      r_resp  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (r_valid && r_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
module tb_axi_lite_regfile;
  logic         clk = 1'b0, rst = 1'b1;
  logic [31:0]  aw_addr = '0, w_data = '0, ar_addr = '0, r_data, status_in = 32'hA5A5_5A5A;
  logic [3:0]   w_strb = '0;
  logic         aw_valid = 0, aw_ready, w_valid = 0, w_ready, b_valid, b_ready = 1;
  logic         ar_valid = 0, ar_ready, r_valid, r_ready = 1;
  logic [1:0]   b_resp, r_resp;
  logic [255:0] regs_out;

  int errors = 0, checks = 0;
  logic [31:0] model [8];
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  logic [1:0]  eb;
  logic [33:0] er;

  axi_lite_regfile dut (
    .clk(clk), .rst(rst),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .status_in(status_in), .regs_out(regs_out)
  );

  always #5 clk = ~clk;

  // Scoreboard: pop an expectation whenever a B or R handshake is about to complete.
  always @(negedge clk) begin
    if (!rst && b_valid && b_ready) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++; $display("FAIL b_unexpected got resp=%0d expected none", b_resp);
      end else begin
        eb = exp_b.pop_front();
        if (b_resp !== eb) begin
          errors++; $display("FAIL b_resp got %0d expected %0d", b_resp, eb);
        end
      end
    end
    if (!rst && r_valid && r_ready) begin
      checks++;
      if (exp_r.size() == 0) begin
        errors++; $display("FAIL r_unexpected got %h expected none", r_data);
      end else begin
        er = exp_r.pop_front();
        if ({r_resp, r_data} !== er) begin
          errors++;
          $display("FAIL r_beat got resp=%0d data=%h expected resp=%0d data=%h",
                   r_resp, r_data, er[33:32], er[31:0]);
        end
      end
    end
  end

  function automatic logic [255:0] model_vec();
    logic [255:0] v = '0;
    for (int i = 0; i < 7; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  function automatic void model_write(input logic [31:0] addr, data, input logic [3:0] strb);
    logic [2:0] idx = addr[4:2];
    logic err = (addr[31:5] != 0) || (idx == 3'd7);
    exp_b.push_back(err ? 2'b10 : 2'b00);
    if (!err) begin
`ifdef AXIL_REGFILE_WSTRB_EN
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
`else
      model[idx] = data;
      if (strb == 4'hx) model[idx] = 'x;
`endif
    end
  endfunction

  function automatic void model_read(input logic [31:0] addr);
    logic [2:0] idx = addr[4:2];
    if (addr[31:5] != 0)  exp_r.push_back({2'b10, 32'h0});
    else if (idx == 3'd7) exp_r.push_back({2'b00, status_in});
    else                  exp_r.push_back({2'b00, model[idx]});
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] addr, data, input logic [3:0] strb);
    int n = 0;
    model_write(addr, data, strb);
    aw_addr = addr; w_data = data; w_strb = strb; aw_valid = 1; w_valid = 1;
    while (!(aw_ready && w_ready) && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL write_timeout addr=%h got no ready expected ready", addr); end
    tick();
    aw_valid = 0; w_valid = 0;
  endtask

  task automatic do_read(input logic [31:0] addr);
    int n = 0;
    model_read(addr);
    ar_addr = addr; ar_valid = 1;
    while (!ar_ready && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL read_timeout addr=%h got no ready expected ready", addr); end
    tick();
    ar_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 100) begin tick(); n++; end
    checks++;
    if (n >= 100) begin
      errors++; $display("FAIL drain got b=%0d r=%0d pending expected 0", exp_b.size(), exp_r.size());
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) model[i] = '0;
    rst = 1; repeat (3) @(posedge clk); #1; rst = 0;
    checks++;
    if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin
      errors++; $display("FAIL reset_ready got %b expected 111", {aw_ready, w_ready, ar_ready});
    end
    checks++;
    if ({b_valid, r_valid, b_resp, r_resp, r_data} !== '0) begin
      errors++; $display("FAIL reset_outputs got bv=%b rv=%b br=%0d rr=%0d rd=%h expected 0",
                         b_valid, r_valid, b_resp, r_resp, r_data);
    end
    checks++;
    if (regs_out !== '0) begin errors++; $display("FAIL reset_regs got %h expected 0", regs_out); end
    // read 0x0: r_valid must appear one cycle after the AR handshake
    model_read(32'h0);
    ar_addr = 32'h0; ar_valid = 1;
    tick();
    ar_valid = 0;
    checks++;
    if (r_valid !== 1'b1) begin errors++; $display("FAIL read_latency got %b expected 1", r_valid); end
    drain();
  endtask

  task automatic test_same_cycle();
    model_write(32'h4, 32'hDEADBEEF, 4'hF);
    aw_addr = 32'h4; w_data = 32'hDEADBEEF; w_strb = 4'hF; aw_valid = 1; w_valid = 1;
    tick();
    aw_valid = 0; w_valid = 0;
    checks++;
    if (b_valid !== 1'b1) begin errors++; $display("FAIL same_cycle_bvalid got %b expected 1", b_valid); end
    checks++;
    if (regs_out[63:32] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL same_cycle_regs_out got %h expected deadbeef", regs_out[63:32]);
    end
    drain();
    do_read(32'h4);
    drain();
  endtask

  task automatic test_w_first();
    w_data = 32'h12345678; w_strb = 4'hF; w_valid = 1;
    tick();
    w_valid = 0;
    checks++;
    if ({w_ready, b_valid} !== 2'b00) begin
      errors++; $display("FAIL w_first_hold got w_ready=%b b_valid=%b expected 0 0", w_ready, b_valid);
    end
    tick(); tick();
    checks++;
    if (b_valid !== 1'b0) begin errors++; $display("FAIL w_first_early_b got %b expected 0", b_valid); end
    model_write(32'h8, 32'h12345678, 4'hF);
    aw_addr = 32'h8; aw_valid = 1;
    tick();
    aw_valid = 0;
    checks++;
    if (b_valid !== 1'b1 || regs_out[95:64] !== 32'h12345678) begin
      errors++; $display("FAIL w_first_commit got bv=%b reg2=%h expected 1 12345678", b_valid, regs_out[95:64]);
    end
    drain();
    do_read(32'h8);
    drain();
  endtask

  task automatic test_errors();
    do_write(32'h1C, 32'h11111111, 4'hF);
    do_write(32'h40, 32'h22222222, 4'hF);
    drain();
    checks++;
    if (regs_out !== model_vec()) begin errors++; $display("FAIL err_no_update got %h expected %h", regs_out, model_vec()); end
    do_read(32'h1C);
    do_read(32'h40);
    drain();
    status_in = 32'h0BADF00D;
    do_read(32'h1C);
    drain();
  endtask

  task automatic test_backpressure();
    b_ready = 0;
    do_write(32'hC, 32'hCAFEF00D, 4'hF);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({b_valid, b_resp, aw_ready, w_ready} !== 5'b1_00_00) begin
        errors++; $display("FAIL b_stall cyc=%0d got bv=%b resp=%0d awr=%b wr=%b expected 1 0 0 0",
                           i, b_valid, b_resp, aw_ready, w_ready);
      end
      tick();
    end
    b_ready = 1;
    drain();
    r_ready = 0;
    do_read(32'hC);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({r_valid, r_resp, r_data, ar_ready} !== {1'b1, 2'b00, 32'hCAFEF00D, 1'b0}) begin
        errors++; $display("FAIL r_stall cyc=%0d got rv=%b resp=%0d data=%h arr=%b expected 1 0 cafef00d 0",
                           i, r_valid, r_resp, r_data, ar_ready);
      end
      tick();
    end
    r_ready = 1;
    drain();
    checks++;
    if ({aw_ready, ar_ready} !== 2'b11) begin errors++; $display("FAIL bp_release got %b expected 11", {aw_ready, ar_ready}); end
  endtask

  task automatic test_back_to_back();
    // valids stay high; one write should be accepted every 2 cycles
    aw_valid = 1; w_valid = 1; w_strb = 4'hF;
    for (int k = 0; k < 4; k++) begin
      aw_addr = 32'hC + 32'(k*4); w_data = 32'h1000_0000 * (k + 1) + 32'(k);
      model_write(aw_addr, w_data, 4'hF);
      checks++;
      if ({aw_ready, w_ready} !== 2'b11) begin errors++; $display("FAIL b2b_ready k=%0d got %b expected 11", k, {aw_ready, w_ready}); end
      tick();
      checks++;
      if ({b_valid, aw_ready} !== 2'b10) begin errors++; $display("FAIL b2b_commit k=%0d got %b expected 10", k, {b_valid, aw_ready}); end
      tick();
    end
    aw_valid = 0; w_valid = 0;
    drain();
    for (int k = 3; k < 7; k++) do_read(32'(k*4));
    drain();
  endtask

  task automatic test_strb();
    do_write(32'h0, 32'hFFFFFFFF, 4'hF);
    do_write(32'h0, 32'h00000000, 4'b0101);
    drain();
    checks++;
`ifdef AXIL_REGFILE_WSTRB_EN
    if (regs_out[31:0] !== 32'hFF00FF00) begin errors++; $display("FAIL strb_reg0 got %h expected ff00ff00", regs_out[31:0]); end
`else
    if (regs_out[31:0] !== 32'h00000000) begin errors++; $display("FAIL strb_reg0 got %h expected 00000000", regs_out[31:0]); end
`endif
    do_read(32'h0);
    drain();
  endtask

  task automatic test_reset_mid();
    w_data = 32'h55555555; w_strb = 4'hF; w_valid = 1;
    tick();
    w_valid = 0;
    rst = 1; #1;
    for (int i = 0; i < 8; i++) model[i] = '0;
    checks++;
    if ({w_ready, b_valid, r_valid} !== 3'b100 || regs_out !== '0) begin
      errors++; $display("FAIL async_reset got wr=%b bv=%b rv=%b regs=%h expected 1 0 0 0", w_ready, b_valid, r_valid, regs_out);
    end
    tick(); rst = 0;
    aw_addr = 32'h10; aw_valid = 1;
    tick();
    aw_valid = 0;
    tick();
    checks++;
    if (b_valid !== 1'b0) begin errors++; $display("FAIL reset_discard got bv=%b expected 0", b_valid); end
    model_write(32'h10, 32'h66666666, 4'hF);
    w_data = 32'h66666666; w_valid = 1;
    tick();
    w_valid = 0;
    checks++;
    if (b_valid !== 1'b1 || regs_out[159:128] !== 32'h66666666) begin
      errors++; $display("FAIL post_reset_commit got bv=%b reg4=%h expected 1 66666666", b_valid, regs_out[159:128]);
    end
    drain();
    do_read(32'h10);
    drain();
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_strb();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
